muldiv_seq: RTL and testbench



---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_signfix.sv | 75 +++++++
 rtl/muldiv_seq.sv | 175 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared opcodes, flag indices and state encoding for the muldiv sequencer
package muldiv_pkg;

  localparam int WIDTH_DEF = 16;

  localparam logic [5:0] OP_MUL  = 6'b010100;
  localparam logic [5:0] OP_DIVQ = 6'b010101;
  localparam logic [5:0] OP_DIVR = 6'b010110;

  localparam int FLG_C = 3;
  localparam int FLG_N = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic op_is_div(input logic [5:0] op);
    return (op == OP_DIVQ) || (op == OP_DIVR);
  endfunction

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_MUL) || op_is_div(op);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - operand magnitude extraction at accept, sign restoration and flags at fix
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]   d,
  input  logic [WIDTH-1:0]   m,
  output logic [WIDTH-1:0]   d_mag,
  output logic [WIDTH-1:0]   m_mag,
  output logic               d_neg,
  output logic               m_neg,
  output logic               div0,
  output logic               min_neg1,
  input  logic [5:0]         op,
  input  logic [2*WIDTH-1:0] prod_mag,
  input  logic [WIDTH-1:0]   quo_mag,
  input  logic [WIDTH-1:0]   rem_mag,
  input  logic [WIDTH-1:0]   op_d_raw,
  input  logic               op_d_neg,
  input  logic               op_m_neg,
  input  logic               op_div0,
  input  logic               op_min_neg1,
  output logic [WIDTH-1:0]   res,
  output logic [3:0]         flg,
  output logic               err
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               ovf;

  always_comb begin
    d_neg    = d[WIDTH-1];
    m_neg    = m[WIDTH-1];
    d_mag    = d_neg ? -d : d;
    m_mag    = m_neg ? -m : m;
    div0     = (m == '0);
    min_neg1 = (d == MIN_VAL) && (m == '1);
  end

  always_comb begin
    prod = (op_d_neg ^ op_m_neg) ? -prod_mag : prod_mag;
    quo  = (op_d_neg ^ op_m_neg) ? -quo_mag : quo_mag;
    rem  = op_d_neg ? -rem_mag : rem_mag;
    res  = '0;
    ovf  = 1'b0;
    err  = 1'b0;
    case (op)
      OP_MUL: begin
        res = prod[WIDTH-1:0];
        // In range only when the top WIDTH+1 bits are a pure sign extension
        ovf = !((&prod[2*WIDTH-1:WIDTH-1]) || (~|prod[2*WIDTH-1:WIDTH-1]));
      end
      OP_DIVQ: begin
        res = op_div0 ? '1 : (op_min_neg1 ? MIN_VAL : quo);
        ovf = op_div0 || op_min_neg1;
      end
      OP_DIVR: begin
        res = op_div0 ? op_d_raw : (op_min_neg1 ? '0 : rem);
        ovf = op_div0 || op_min_neg1;
      end
      default: err = 1'b1;
    endcase
    flg        = '0;
    flg[FLG_C] = 1'b0;
    flg[FLG_N] = !err && res[WIDTH-1];
    flg[FLG_Z] = err || (res == '0);
    flg[FLG_V] = !err && ovf;
  end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle signed multiply/divide sequencer; MULDIV_EARLY_TERM_EN enables variable latency
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] M,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [5:0]         op_q, op_d;
  logic [WIDTH-1:0]   d_raw_q, d_raw_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic               d_neg_q, d_neg_d, m_neg_q, m_neg_d;
  logic               div0_q, div0_d, mn1_q, mn1_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic               done_q, done_d, err_q, err_d;

  logic [WIDTH-1:0]   in_d_mag, in_m_mag, fix_res;
  logic               in_d_neg, in_m_neg, in_div0, in_mn1, fix_err;
  logic [3:0]         fix_flg;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH+1:0]   trial;
  logic               skip_run, mul_early;

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .d(D), .m(M),
    .d_mag(in_d_mag), .m_mag(in_m_mag),
    .d_neg(in_d_neg), .m_neg(in_m_neg),
    .div0(in_div0), .min_neg1(in_mn1),
    .op(op_q), .prod_mag(acc_q), .quo_mag(mplier_q), .rem_mag(acc_q[WIDTH-1:0]),
    .op_d_raw(d_raw_q), .op_d_neg(d_neg_q), .op_m_neg(m_neg_q),
    .op_div0(div0_q), .op_min_neg1(mn1_q),
    .res(fix_res), .flg(fix_flg), .err(fix_err)
  );

`ifdef MULDIV_EARLY_TERM_EN
  assign skip_run  = !op_supported(opcode) || (op_is_div(opcode) && in_div0);
  assign mul_early = (op_q == OP_MUL) && (mplier_q[WIDTH-1:1] == '0);
`else
  assign skip_run  = 1'b0;
  assign mul_early = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      d_raw_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      d_neg_q  <= 1'b0;
      m_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      mn1_q    <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      d_raw_q  <= d_raw_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      d_neg_q  <= d_neg_d;
      m_neg_q  <= m_neg_d;
      div0_q   <= div0_d;
      mn1_q    <= mn1_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = skip_run ? FIX : RUN;
      RUN:     if ((count_q == CW'(WIDTH-1)) || mul_early) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d   = count_q;
    op_d      = op_q;
    d_raw_d   = d_raw_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    d_neg_d   = d_neg_q;
    m_neg_d   = m_neg_q;
    div0_d    = div0_q;
    mn1_d     = mn1_q;
    result_d  = result_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    // Divide reuses acc as the partial remainder and mplier as the dividend/quotient shifter
    rem_shift = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
    trial     = {1'b0, rem_shift} - {2'b00, mcand_q[WIDTH-1:0]};
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = opcode;
          d_raw_d = D;
          d_neg_d = in_d_neg;
          m_neg_d = in_m_neg;
          div0_d  = in_div0;
          mn1_d   = in_mn1;
          count_d = '0;
          acc_d   = '0;
          if (opcode == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, in_d_mag};
            mplier_d = in_m_mag;
          end else begin
            mcand_d  = {{WIDTH{1'b0}}, in_m_mag};
            mplier_d = in_d_mag;
          end
        end
      end
      RUN: begin
        count_d = count_q + CW'(1);
        if (op_q == OP_MUL) begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end else begin
          acc_d    = trial[WIDTH+1] ? {{(WIDTH-1){1'b0}}, rem_shift}
                                    : {{(WIDTH-1){1'b0}}, trial[WIDTH:0]};
          mplier_d = {mplier_q[WIDTH-2:0], ~trial[WIDTH+1]};
        end
      end
      FIX: begin
        result_d = fix_res;
        flags_d  = fix_flg;
        err_d    = fix_err;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized and directed checks of muldiv_seq against an arithmetic reference model
module tb_muldiv_seq;

  localparam logic [5:0] T_MUL  = 6'b010100;
  localparam logic [5:0] T_DIVQ = 6'b010101;
  localparam logic [5:0] T_DIVR = 6'b010110;
  localparam int FULL_LAT = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  opcode = '0;
  logic [15:0] D = '0;
  logic [15:0] M = '0;
  logic        busy, done, err;
  logic [15:0] result;
  logic [3:0]  flags;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .D(D), .M(M), .busy(busy), .done(done),
    .result(result), .flags(flags), .err(err)
  );

  function automatic void model(input logic [5:0] op, input logic [15:0] d, input logic [15:0] m,
                                output logic [15:0] r, output logic [3:0] f, output logic e);
    int sd, sm, p, q, rm;
    logic v;
    sd = int'($signed(d));
    sm = int'($signed(m));
    v = 1'b0; e = 1'b0; r = '0;
    if (op == T_MUL) begin
      p = sd * sm;
      r = 16'(p);
      v = (p < -32768) || (p > 32767);
    end else if (op == T_DIVQ || op == T_DIVR) begin
      if (sm == 0) begin
        q = -1; rm = sd; v = 1'b1;
      end else if (sd == -32768 && sm == -1) begin
        q = -32768; rm = 0; v = 1'b1;
      end else begin
        q = sd / sm; rm = sd % sm;
      end
      r = (op == T_DIVQ) ? 16'(q) : 16'(rm);
    end else begin
      e = 1'b1;
    end
    f = e ? 4'b0010 : {1'b0, r[15], (r == 16'd0), v};
  endfunction

  // Called one step after an edge with the block idle; returns in the done cycle
  task automatic run_op(input logic [5:0] op, input logic [15:0] d, input logic [15:0] m,
                        output logic [15:0] r, output logic [3:0] f, output logic e, output int lat);
    req_valid = 1'b1; opcode = op; D = d; M = m;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; f = flags; e = err;
  endtask

  task automatic check_op(input string name, input logic [5:0] op, input logic [15:0] d,
                          input logic [15:0] m, input int exp_lat);
    logic [15:0] r, er;
    logic [3:0]  f, ef;
    logic        e, ee;
    int          lat;
    model(op, d, m, er, ef, ee);
    run_op(op, d, m, r, f, e, lat);
    tests_run++;
    if (r !== er || f !== ef || e !== ee) begin
      tests_failed++;
      $display("FAIL %s op=%b D=%h M=%h: got res=%h flags=%b err=%b, want res=%h flags=%b err=%b",
               name, op, d, m, r, f, e, er, ef, ee);
    end
    tests_run++;
    if ((exp_lat > 0) ? (lat != exp_lat) : (lat > FULL_LAT)) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d, want %0d", name, lat, (exp_lat > 0) ? exp_lat : FULL_LAT);
    end
  endtask

  task automatic test_reset;
    tests_run++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        result !== 16'd0 || flags !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset: got ready=%b busy=%b done=%b err=%b res=%h flags=%b, want 1 0 0 0 0000 0000",
               req_ready, busy, done, err, result, flags);
    end
  endtask

  task automatic test_directed;
    int fl;
`ifdef MULDIV_EARLY_TERM_EN
    fl = 0;
`else
    fl = FULL_LAT;
`endif
    check_op("mul_300_m7", T_MUL, 16'd300, 16'hFFF9, fl);
    tests_run++;
    if (result !== 16'hF7CC || flags !== 4'b0100) begin
      tests_failed++;
      $display("FAIL mul_const: got %h/%b, want f7cc/0100", result, flags);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_pulse: got done=%b, want 0", done);
    end
    check_op("mul_300_300", T_MUL, 16'd300, 16'd300, fl);
    check_op("mul_0_m5", T_MUL, 16'd0, 16'hFFFB, fl);
    check_op("divq_m7_2", T_DIVQ, 16'hFFF9, 16'd2, fl);
    check_op("divr_m7_2", T_DIVR, 16'hFFF9, 16'd2, fl);
    check_op("divr_7_m2", T_DIVR, 16'd7, 16'hFFFE, fl);
`ifdef MULDIV_EARLY_TERM_EN
    check_op("divq_5_0", T_DIVQ, 16'd5, 16'd0, 2);
    check_op("divr_5_0", T_DIVR, 16'd5, 16'd0, 2);
`else
    check_op("divq_5_0", T_DIVQ, 16'd5, 16'd0, fl);
    check_op("divr_5_0", T_DIVR, 16'd5, 16'd0, fl);
`endif
    check_op("divq_min_m1", T_DIVQ, 16'h8000, 16'hFFFF, fl);
    check_op("divr_min_m1", T_DIVR, 16'h8000, 16'hFFFF, fl);
  endtask

  task automatic test_random;
    logic [5:0]  op;
    logic [15:0] d, m;
    int fl;
`ifdef MULDIV_EARLY_TERM_EN
    fl = 0;
`else
    fl = FULL_LAT;
`endif
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: op = T_MUL;
        1: op = T_DIVQ;
        default: op = T_DIVR;
      endcase
      d = 16'($urandom);
      m = 16'($urandom);
      case ($urandom_range(0, 7))
        0: m = 16'd0;
        1: m = 16'hFFFF;
        2: begin d = 16'h8000; m = 16'hFFFF; end
        3: begin d = 16'($urandom_range(0, 255)); m = 16'($urandom_range(0, 255)); end
        default: ;
      endcase
      if (fl == 0 && op != T_MUL && m == 16'd0)
        check_op("random", op, d, m, 2);
      else
        check_op("random", op, d, m, fl);
    end
  endtask

  task automatic test_unsupported;
`ifdef MULDIV_EARLY_TERM_EN
    check_op("unsupported", 6'b000001, 16'h1234, 16'h0042, 2);
`else
    check_op("unsupported", 6'b000001, 16'h1234, 16'h0042, FULL_LAT);
`endif
    @(posedge clk); #1;
    tests_run++;
    if (err !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_pulse: got err=%b done=%b, want 0 0", err, done);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] er;
    logic [3:0]  ef;
    logic        ee;
    int          n;
    logic        ready_bad;
    req_valid = 1'b1; opcode = T_MUL; D = 16'd1234; M = 16'hFF85;
    @(posedge clk); #1;
    opcode = T_DIVQ; D = 16'd1000; M = 16'd7;
    n = 1; ready_bad = 1'b0;
    while (done !== 1'b1 && n < 60) begin
      if (req_ready !== 1'b0) ready_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    tests_run++;
    if (ready_bad) begin
      tests_failed++;
      $display("FAIL b2b_ready_busy: got req_ready=1 while busy, want 0");
    end
    model(T_MUL, 16'd1234, 16'hFF85, er, ef, ee);
    tests_run++;
    if (done !== 1'b1 || result !== er || flags !== ef || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_first: got done=%b res=%h flags=%b ready=%b, want 1 %h %b 1",
               done, result, flags, req_ready, er, ef);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_accept: got busy=%b, want 1", busy);
    end
    n = 1;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    model(T_DIVQ, 16'd1000, 16'd7, er, ef, ee);
    tests_run++;
    if (done !== 1'b1 || result !== er || flags !== ef) begin
      tests_failed++;
      $display("FAIL b2b_second: got done=%b res=%h flags=%b, want 1 %h %b", done, result, flags, er, ef);
    end
`ifndef MULDIV_EARLY_TERM_EN
    tests_run++;
    if (n != FULL_LAT) begin
      tests_failed++;
      $display("FAIL b2b_latency: got %0d, want %0d", n, FULL_LAT);
    end
`endif
  endtask

  task automatic test_reset_mid;
    logic saw_done;
    req_valid = 1'b1; opcode = T_MUL; D = 16'd99; M = 16'hFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        result !== 16'd0 || flags !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: got ready=%b busy=%b done=%b err=%b res=%h flags=%b, want 1 0 0 0 0000 0000",
               req_ready, busy, done, err, result, flags);
    end
    #2 rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    tests_run++;
    if (saw_done) begin
      tests_failed++;
      $display("FAIL reset_mid_no_done: got done after reset, want none");
    end
    check_op("after_reset", T_DIVR, 16'd100, 16'd7, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed;
    test_random;
    test_unsupported;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
